riscboy_ppu_palette_loader: RTL and testbench
=============================================

# riscboy_ppu_palette_loader

Sequences all writes into the PPU palette RAM write port (`pram_waddr`/`pram_wdata`/`pram_wen`) of the palette mapper. It merges two sources:
- single-entry CPU register writes;
- a bulk-load engine that fetches a run of palette entries from system memory over a pipelined read interface and streams them into consecutive palette indices.

Memory responses have priority, and the CPU is stalled on collision.

## Interface

Parameters:
- `W_PIXDATA`, 16, palette entry width; must be a multiple of 8.
- `W_PALETTE_IDX`, 8, palette index width.
- `W_ADDR`, 32, memory byte-address width.
- `MAX_OUTSTANDING`, 2, maximum in-flight memory reads (1..3).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `cpu_wen`  in  1  CPU write request.
- `cpu_waddr`  in  `W_PALETTE_IDX`  CPU write index.
- `cpu_wdata`  in  `W_PIXDATA`  CPU write data.
- `cpu_wready`  out  1  CPU write accepted this cycle if `cpu_wen`.
- `load_start`  in  1  start bulk load (pulse).
- `load_base`  in  `W_ADDR`  memory byte address of first entry.
- `load_first`  in  `W_PALETTE_IDX`  first palette index.
- `load_count`  in  `W_PALETTE_IDX+1`  entry count, 0..2^`W_PALETTE_IDX`.
- `load_busy`  out  1  bulk load in progress.
- `load_done`  out  1  one-cycle completion pulse.
- `mem_req_vld`  out  1  read request valid.
- `mem_req_rdy`  in  1  read request accepted.
- `mem_req_addr`  out  `W_ADDR`  read byte address.
- `mem_rsp_vld`  in  1  read data valid; always accepted, in request order.
- `mem_rsp_data`  in  `W_PIXDATA`  read data.
- `pram_waddr`  out  `W_PALETTE_IDX`  palette write index (registered).
- `pram_wdata`  out  `W_PIXDATA`  palette write data (registered).
- `pram_wen`  out  1  palette write enable (registered).

## Operation

- FSM states: IDLE, ISSUE, DRAIN.
- IDLE + `load_start`:
  - latch `load_base` with the low log2(`W_PIXDATA`/8) bits forced to 0 as `req_addr`;
  - latch `load_first` as `wr_idx`;
  - latch `load_count` as both `req_left` and `rsp_left`.
  - If count != 0, go to ISSUE. If count == 0, stay in IDLE and pulse `load_done` next cycle with no requests.
- `load_start` while not IDLE is ignored.
- ISSUE:
  - `mem_req_vld` = (`req_left` != 0) && (`outstanding` < `MAX_OUTSTANDING`).
  - On `mem_req_vld && mem_req_rdy`: `req_addr` += `W_PIXDATA`/8, `req_left`--, `outstanding`++.
  - When the last request handshakes, go to DRAIN.
- `outstanding` tracks in-flight reads:
  - request handshake and response in the same cycle → unchanged;
  - response decrements it.
- On each `mem_rsp_vld`, in any busy state:
  - register a PRAM write of `mem_rsp_data` to `wr_idx`;
  - `wr_idx` increments modulo 2^`W_PALETTE_IDX` (wraps 255 → 0);
  - `rsp_left`--.
- When the response taking `rsp_left` to 0 is accepted, go to IDLE and assert `load_done` for one cycle. This can happen from ISSUE or DRAIN.
- `mem_rsp_vld` when `outstanding` == 0 or in IDLE is a protocol violation: ignored, no PRAM write.
- CPU path:
  - `cpu_wready` = !`mem_rsp_vld` (combinational).
  - A CPU write with `cpu_wen && cpu_wready` registers a PRAM write of `cpu_wdata` to `cpu_waddr`.
  - CPU writes are permitted during a bulk load, between responses.
- `mem_req_addr` wraps modulo 2^`W_ADDR`.
- `load_busy` = (state != IDLE), registered.

## Timing

- Reset values: `pram_wen`=0, `pram_waddr`=0, `pram_wdata`=0, `mem_req_vld`=0, `mem_req_addr`=0, `load_busy`=0, `load_done`=0. Internal counters are 0.
  - `cpu_wready`=1 whenever `mem_rsp_vld`=0, including during reset.
- `load_start` at cycle 0 → `load_busy`=1 and `mem_req_vld`=1 at cycle 1.
- Accepted CPU write or memory response at cycle t → `pram_wen`=1 with its data/index at t+1. `pram_wen` is a one-cycle pulse per write.
- Final response at cycle t:
  - the last PRAM write, `load_done`=1 and `load_busy`=0 all appear at t+1;
  - a new `load_start` at t+1 is accepted.
- Minimum load duration for N entries with zero-latency memory: N+1 cycles to `load_done`.
- `mem_req_vld` is not withdrawn before handshake. `mem_req_addr` is stable while `mem_req_vld && !mem_req_rdy`.
- Reset mid-load:
  - FSM returns to IDLE immediately; `load_done` is not pulsed.
  - In-flight responses arriving after reset are ignored.

## Test plan

- Basic load: `load_base`=0x1000, `load_first`=0x10, `load_count`=4, memory always ready with 1-cycle latency, data 0xA000+i.
  - Requests go to 0x1000, 0x1002, 0x1004, 0x1006.
  - `pram_wen` writes indices 0x10..0x13 with 0xA000..0xA003.
  - `load_done` pulses once; `load_busy` is high for exactly the load duration.
- Wrap-around: `load_first`=0xFE, `load_count`=4 → writes indices 0xFE, 0xFF, 0x00, 0x01 in order.
- Outstanding limit: `mem_req_rdy`=1, responses delayed 5 cycles → never more than 2 unanswered requests; `mem_req_vld` drops while at the limit.
- Collision: `cpu_wen` held (idx 0x05, data 0x1234) in the same cycle as `mem_rsp_vld`.
  - `cpu_wready`=0 in that cycle; the memory entry is written first.
  - The CPU write lands the cycle after `mem_rsp_vld` falls; no writes are lost.
- Zero count and ignored start: `load_count`=0 → `load_done` at cycle 1 with no `mem_req_vld`. A `load_start` during a busy load → no effect on the addresses or indices being written.
- Reset mid-load: assert `rst` after 2 of 8 responses → all outputs at reset values next cycle. Late responses cause no `pram_wen`, and no `load_done` is pulsed.

Source files
------------

// File: rtl/riscboy_ppu_palette_loader.sv
// Palette RAM write sequencer: merges CPU register writes with a bulk loader that streams
// palette entries from memory into consecutive palette indices. Memory responses win collisions.
module riscboy_ppu_palette_loader #(
    parameter int unsigned W_PIXDATA       = 16,
    parameter int unsigned W_PALETTE_IDX   = 8,
    parameter int unsigned W_ADDR          = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     cpu_wen,
    input  logic [W_PALETTE_IDX-1:0] cpu_waddr,
    input  logic [W_PIXDATA-1:0]     cpu_wdata,
    output logic                     cpu_wready,

    input  logic                     load_start,
    input  logic [W_ADDR-1:0]        load_base,
    input  logic [W_PALETTE_IDX-1:0] load_first,
    input  logic [W_PALETTE_IDX:0]   load_count,
    output logic                     load_busy,
    output logic                     load_done,

    output logic                     mem_req_vld,
    input  logic                     mem_req_rdy,
    output logic [W_ADDR-1:0]        mem_req_addr,
    input  logic                     mem_rsp_vld,
    input  logic [W_PIXDATA-1:0]     mem_rsp_data,

    output logic [W_PALETTE_IDX-1:0] pram_waddr,
    output logic [W_PIXDATA-1:0]     pram_wdata,
    output logic                     pram_wen
);

    localparam int unsigned BYTES_PER_ENTRY = W_PIXDATA / 8;
    localparam int unsigned ALIGN_BITS      = $clog2(BYTES_PER_ENTRY);
    localparam int unsigned W_COUNT         = W_PALETTE_IDX + 1;

    localparam logic [W_ADDR-1:0]  ADDR_MASK = ~((W_ADDR'(1) << ALIGN_BITS) - W_ADDR'(1));
    localparam logic [W_ADDR-1:0]  ADDR_STEP = W_ADDR'(BYTES_PER_ENTRY);
    localparam logic [1:0]         OUT_MAX   = 2'(MAX_OUTSTANDING);
    localparam logic [W_COUNT-1:0] COUNT_ONE = W_COUNT'(1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } state_e;

    state_e                   state_q, state_d;
    logic [W_ADDR-1:0]        req_addr_q, req_addr_d;
    logic [W_COUNT-1:0]       req_left_q, req_left_d;
    logic [W_COUNT-1:0]       rsp_left_q, rsp_left_d;
    logic [W_PALETTE_IDX-1:0] wr_idx_q, wr_idx_d;
    logic [1:0]               outstanding_q, outstanding_d;
    logic                     load_busy_q, load_done_q, load_done_d;
    logic                     pram_wen_q, pram_wen_d;
    logic [W_PALETTE_IDX-1:0] pram_waddr_q, pram_waddr_d;
    logic [W_PIXDATA-1:0]     pram_wdata_q, pram_wdata_d;

    logic req_hs;
    logic rsp_ok;
    logic cpu_ok;

    assign mem_req_vld  = (state_q == StIssue) && (req_left_q != '0) && (outstanding_q < OUT_MAX);
    assign mem_req_addr = req_addr_q;
    assign cpu_wready   = !mem_rsp_vld;

    assign req_hs = mem_req_vld && mem_req_rdy;
    // Stray responses (idle, or nothing in flight) are dropped but still stall the CPU.
    assign rsp_ok = mem_rsp_vld && (state_q != StIdle) && (outstanding_q != '0);
    assign cpu_ok = cpu_wen && cpu_wready;

    always_comb begin
        state_d       = state_q;
        req_addr_d    = req_addr_q;
        req_left_d    = req_left_q;
        rsp_left_d    = rsp_left_q;
        wr_idx_d      = wr_idx_q;
        outstanding_d = outstanding_q;
        load_done_d   = 1'b0;
        pram_wen_d    = 1'b0;
        pram_waddr_d  = pram_waddr_q;
        pram_wdata_d  = pram_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    req_addr_d    = load_base & ADDR_MASK;
                    wr_idx_d      = load_first;
                    req_left_d    = load_count;
                    rsp_left_d    = load_count;
                    outstanding_d = '0;
                    if (load_count == '0) begin
                        load_done_d = 1'b1;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (req_hs && (req_left_q == COUNT_ONE)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (req_hs) begin
            req_addr_d = req_addr_q + ADDR_STEP;
            req_left_d = req_left_q - COUNT_ONE;
        end

        if (req_hs && !rsp_ok) begin
            outstanding_d = outstanding_q + 2'd1;
        end else if (!req_hs && rsp_ok) begin
            outstanding_d = outstanding_q - 2'd1;
        end

        if (rsp_ok) begin
            pram_wen_d   = 1'b1;
            pram_waddr_d = wr_idx_q;
            pram_wdata_d = mem_rsp_data;
            wr_idx_d     = wr_idx_q + 1'b1;
            rsp_left_d   = rsp_left_q - COUNT_ONE;
            if (rsp_left_q == COUNT_ONE) begin
                state_d     = StIdle;
                load_done_d = 1'b1;
            end
        end else if (cpu_ok) begin
            pram_wen_d   = 1'b1;
            pram_waddr_d = cpu_waddr;
            pram_wdata_d = cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            req_addr_q    <= '0;
            req_left_q    <= '0;
            rsp_left_q    <= '0;
            wr_idx_q      <= '0;
            outstanding_q <= '0;
            load_busy_q   <= 1'b0;
            load_done_q   <= 1'b0;
            pram_wen_q    <= 1'b0;
            pram_waddr_q  <= '0;
            pram_wdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            req_addr_q    <= req_addr_d;
            req_left_q    <= req_left_d;
            rsp_left_q    <= rsp_left_d;
            wr_idx_q      <= wr_idx_d;
            outstanding_q <= outstanding_d;
            load_busy_q   <= (state_d != StIdle);
            load_done_q   <= load_done_d;
            pram_wen_q    <= pram_wen_d;
            pram_waddr_q  <= pram_waddr_d;
            pram_wdata_q  <= pram_wdata_d;
        end
    end

    assign load_busy  = load_busy_q;
    assign load_done  = load_done_q;
    assign pram_wen   = pram_wen_q;
    assign pram_waddr = pram_waddr_q;
    assign pram_wdata = pram_wdata_q;

endmodule

// File: tb/tb_riscboy_ppu_palette_loader.sv
// Randomised bench for riscboy_ppu_palette_loader: an in-order memory responder plus a
// transaction-level model of the expected palette write stream, handshakes and status.
module tb_riscboy_ppu_palette_loader;

    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_wen = 1'b0;
    logic [7:0]  cpu_waddr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_wready;
    logic        load_start = 1'b0;
    logic [31:0] load_base = '0;
    logic [7:0]  load_first = '0;
    logic [8:0]  load_count = '0;
    logic        load_busy, load_done;
    logic        mem_req_vld;
    logic        mem_req_rdy = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_vld = 1'b0;
    logic [15:0] mem_rsp_data = '0;
    logic [7:0]  pram_waddr;
    logic [15:0] pram_wdata;
    logic        pram_wen;

    always #5 clk = ~clk;

    riscboy_ppu_palette_loader #(
        .W_PIXDATA      (16),
        .W_PALETTE_IDX  (8),
        .W_ADDR         (32),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_wen     (cpu_wen),
        .cpu_waddr   (cpu_waddr),
        .cpu_wdata   (cpu_wdata),
        .cpu_wready  (cpu_wready),
        .load_start  (load_start),
        .load_base   (load_base),
        .load_first  (load_first),
        .load_count  (load_count),
        .load_busy   (load_busy),
        .load_done   (load_done),
        .mem_req_vld (mem_req_vld),
        .mem_req_rdy (mem_req_rdy),
        .mem_req_addr(mem_req_addr),
        .mem_rsp_vld (mem_rsp_vld),
        .mem_rsp_data(mem_rsp_data),
        .pram_waddr  (pram_waddr),
        .pram_wdata  (pram_wdata),
        .pram_wen    (pram_wen)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // In-order memory responder.
    typedef struct {
        logic [15:0] data;
        int          due;
    } rsp_t;
    rsp_t rq[$];
    int   cyc = 0;
    int   lat_min = 1, lat_max = 1, rdy_pct = 100;

    // Load model: one transaction described by base/first/count and progress counters.
    bit          m_busy = 0;
    logic [31:0] m_base = '0;
    logic [7:0]  m_first = '0;
    int          m_count = 0, m_nreq = 0, m_nrsp = 0;
    logic [15:0] m_salt = '0, salt_next = '0;
    bit          e_wen = 0, e_done = 0;
    logic [7:0]  e_waddr = '0;
    logic [15:0] e_wdata = '0;
    bit          cpu_pend = 0;

    task automatic cycle();
        bit   exp_vld, hs, racc, busy0;
        int   outs;
        rsp_t r;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            mem_rsp_vld  = 1'b1;
            mem_rsp_data = rq[0].data;
            void'(rq.pop_front());
        end else begin
            mem_rsp_vld  = 1'b0;
            mem_rsp_data = 16'($urandom);
        end
        mem_req_rdy = ($urandom_range(99) < rdy_pct);
        cpu_wen     = cpu_pend;
        #1;
        check_val("cpu_wready", cpu_wready, !mem_rsp_vld);
        outs    = m_nreq - m_nrsp;
        exp_vld = m_busy && (m_nreq < m_count) && (outs < MAX_OUT);
        if (!rst) begin
            check_val("mem_req_vld", mem_req_vld, exp_vld);
            if (exp_vld) check_val("mem_req_addr", mem_req_addr, m_base + 32'(2 * m_nreq));
        end
        if (mem_req_vld === 1'b1 && mem_req_rdy) begin
            r.data = m_salt ^ (16'hA000 + 16'(m_nreq));
            r.due  = cyc + $urandom_range(lat_min, lat_max);
            rq.push_back(r);
        end
        hs     = exp_vld && mem_req_rdy;
        busy0  = m_busy;
        e_done = 0;
        e_wen  = 0;
        if (rst) begin
            m_busy   = 0;
            e_waddr  = '0;
            e_wdata  = '0;
            cpu_pend = 0;
        end else begin
            racc = m_busy && mem_rsp_vld && (outs > 0);
            if (racc) begin
                e_wen   = 1;
                e_waddr = m_first + 8'(m_nrsp);
                e_wdata = m_salt ^ (16'hA000 + 16'(m_nrsp));
                m_nrsp++;
                if (m_nrsp == m_count) begin
                    m_busy = 0;
                    e_done = 1;
                end
            end else if (cpu_wen && !mem_rsp_vld) begin
                e_wen    = 1;
                e_waddr  = cpu_waddr;
                e_wdata  = cpu_wdata;
                cpu_pend = 0;
            end
            if (hs) m_nreq++;
            if (load_start && !busy0) begin
                m_base  = load_base & 32'hFFFF_FFFE;
                m_first = load_first;
                m_count = int'(load_count);
                m_nreq  = 0;
                m_nrsp  = 0;
                m_salt  = salt_next;
                if (m_count == 0) e_done = 1;
                else m_busy = 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check_val("pram_wen", pram_wen, e_wen);
        if (e_wen) begin
            check_val("pram_waddr", pram_waddr, e_waddr);
            check_val("pram_wdata", pram_wdata, e_wdata);
        end
        check_val("load_busy", load_busy, m_busy);
        check_val("load_done", load_done, e_done);
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_val("rst_pram_waddr", pram_waddr, 0);
        check_val("rst_pram_wdata", pram_wdata, 0);
        check_val("rst_mem_req_addr", mem_req_addr, 0);
        check_val("rst_mem_req_vld", mem_req_vld, 0);
    endtask

    task automatic run_load(input logic [31:0] base, input logic [7:0] first, input int count,
                            input int cpu_at, input bit noise);
        load_base  = base;
        load_first = first;
        load_count = 9'(count);
        load_start = 1'b1;
        cycle();
        for (int i = 0; i < 4000 && m_busy; i++) begin
            if (i == cpu_at) begin
                cpu_pend  = 1;
                cpu_waddr = 8'h05;
                cpu_wdata = 16'h1234;
            end
            if (noise) begin
                if (!cpu_pend && $urandom_range(7) == 0) begin
                    cpu_pend  = 1;
                    cpu_waddr = 8'($urandom);
                    cpu_wdata = 16'($urandom);
                end
                if ($urandom_range(15) == 0) begin
                    load_start = 1'b1;
                    load_base  = $urandom;
                    load_first = 8'($urandom);
                    load_count = 9'($urandom_range(0, 256));
                end
            end
            cycle();
        end
        if (m_busy) begin
            check_val("load_timeout", 1, 0);
            do_reset();
        end
        for (int i = 0; i < 200 && (rq.size() > 0 || cpu_pend); i++) cycle();
        cycle();
    endtask

    initial begin
        do_reset();
        cycle();

        // Basic load, 1-cycle latency, data A000+i.
        salt_next = '0; lat_min = 1; lat_max = 1; rdy_pct = 100;
        run_load(32'h0000_1000, 8'h10, 4, -1, 0);
        // Wrap-around of palette index.
        run_load(32'h0000_2001, 8'hFE, 4, -1, 0);
        // Outstanding limit with 5-cycle latency.
        lat_min = 5; lat_max = 5;
        run_load(32'h0000_3000, 8'h40, 8, -1, 0);
        // Collision: CPU write raised as the response stream starts.
        lat_min = 1; lat_max = 1;
        run_load(32'h0000_4000, 8'h20, 4, 1, 0);
        // Zero count.
        run_load(32'h0000_5000, 8'h00, 0, -1, 0);
        // Ignored starts and CPU traffic during a load; full 256-entry load wrapping address.
        salt_next = 16'h5A5A; lat_min = 1; lat_max = 3; rdy_pct = 70;
        run_load(32'hFFFF_FF80, 8'h80, 256, -1, 1);

        // Reset after 2 of 8 responses; late responses must be ignored.
        lat_min = 2; lat_max = 4; rdy_pct = 100;
        load_base = 32'h0000_6000; load_first = 8'h30; load_count = 9'd8; load_start = 1'b1;
        cycle();
        for (int i = 0; i < 500 && m_nrsp < 2; i++) cycle();
        do_reset();
        for (int i = 0; i < 20; i++) cycle();

        // Randomised loads.
        for (int n = 0; n < 25; n++) begin
            salt_next = 16'($urandom);
            lat_min   = 1;
            lat_max   = $urandom_range(1, 6);
            rdy_pct   = $urandom_range(30, 100);
            run_load($urandom, 8'($urandom), $urandom_range(0, 24), -1, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
